thunderbird_seq: RTL and testbench
==================================

# thunderbird_seq

Parametrised tail-light sequencer for the Thunderbird lamp cluster. It replaces the fixed pair of 3-lamp side modules with one block. The block drives LAMPS lamps per side and adds four things the old modules lacked: a hazard mode, a brake override, a tick prescaler, and priority resolution between simultaneous requests. It sits between the debounced driver switch inputs and the lamp drivers; all outputs are registered.

## Interface
- LAMPS, 3: lamps per side, ≥1; bit 0 is the innermost lamp (A), bit LAMPS-1 the outermost (C for LAMPS=3).
- DIV, 4: clock cycles per sequence step, ≥1; DIV=1 steps every cycle.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset; release synchronised externally.
- left  in  1  left-turn request, level.
- right  in  1  right-turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- left_lamps  out  LAMPS  left lamp states, 1 = lit.
- right_lamps  out  LAMPS  right lamp states, 1 = lit.
- mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.

## Operation
- **Reset (rst_n=0):** outputs clear immediately, independent of clk.
  - mode=IDLE, step=0, prescaler=0.
  - left_lamps=0, right_lamps=0.
- **Requested mode**, evaluated every cycle in priority order:
  - hazard=1 → HAZARD.
  - left=1 and right=1 → HAZARD.
  - left=1 → LEFT.
  - right=1 → RIGHT.
  - otherwise → IDLE.
- **Mode change:** when the requested mode differs from the current mode, the next edge loads the new mode with step=0 and prescaler=0. A change mid-sequence abandons the old sequence; there is no completion of the old pattern.
- **Prescaler:** counts 0..DIV-1. Tick = (prescaler==DIV-1). On a tick the prescaler wraps to 0. The prescaler only runs when mode≠IDLE; in IDLE it holds at 0.
- **LEFT/RIGHT step counter:** on each tick, step goes 0→1→…→LAMPS→0 (wrap).
- **Active side pattern:** thermometer, lamps[i] = (i < step). Step 0 is all off; step LAMPS is all lit.
- **HAZARD:** step toggles 0↔1 on each tick. Both sides = all ones when step=1, all zeros when step=0.
- **Brake override:**
  - Any side not currently sequencing shows all ones while brake=1, zeros while brake=0.
  - In IDLE this applies to both sides.
  - In LEFT it applies to the right side; in RIGHT it applies to the left side.
  - In HAZARD brake has no effect.
- **Step counter width:** $clog2(LAMPS+1). The prescaler is $clog2(DIV) bits, with a minimum of 1.

## Timing
- Inputs are sampled at an edge; outputs reflect the new mode, step and brake at that same edge. Latency from input change to output is 1 edge.
- **Mode entry** at edge E: active lamps = 0 at E.
  - Lamp 0 lights at E+DIV.
  - Lamp k lights at E+(k+1)·DIV.
  - Step returns to 0 at E+(LAMPS+1)·DIV.
  - Sequence period = (LAMPS+1)·DIV cycles.
- **HAZARD entry** at E: all off at E, all on at E+DIV, off at E+2·DIV. Period = 2·DIV.
- **Request dropped** (→IDLE): lamps go to brake-determined values on the next edge; there is no drain.
- **Simultaneous events:**
  - left and right rising on the same edge → HAZARD.
  - Dropping right while in HAZARD from left&right, with hazard=0 → LEFT, restarted from step 0.
  - Brake changing mid-sequence affects only the non-active side and does not disturb step or prescaler.
- **Held request:** the sequence repeats indefinitely.
- **Reset mid-sequence:** outputs clear asynchronously. After rst_n rises, a held request enters its mode on the first edge and the sequence restarts at step 0.

## Test plan
All scenarios use LAMPS=3, DIV=4.
1. **Reset:** hold rst_n=0 with left=1 and brake=1 → lamps 000/000 and mode=0 throughout. Assert rst_n=0 mid-sequence → lamps go to 0 before the next clk edge.
2. **Left sequence:** left=1 held from edge E → left_lamps = 000 at E, 001 at E+4, 011 at E+8, 111 at E+12, 000 at E+16, 001 at E+20. right_lamps=000 throughout; mode=1.
3. **Right with brake:** right=1 and brake=1 → right_lamps follows the thermometer sequence, left_lamps=111 steady. Drop brake → left_lamps=000 on the next edge, with no skew in the right_lamps step timing.
4. **Hazard priority:** left=1 and right=1 together → mode=3, both sides 000, 111, 000 at E, E+4, E+8. Add brake=1 → no change.
5. **Mid-sequence switch:** left=1 until left_lamps=011, then left=0 with right=1 on the same edge → next edge mode=2, left_lamps=000, right_lamps=000; right_lamps=001 four cycles later.
6. **Idle brake:** all requests 0, brake pulsed for 3 cycles → both sides 111 for exactly 3 edges, then 000; prescaler stays at 0.

Source files
------------

// File: rtl/thunderbird_seq.sv
// thunderbird_seq
// Tail-light sequencer for the Thunderbird lamp cluster. A single block that
// drives LAMPS lamps on each side. It supports left/right turn sequences,
// hazard flashing and brake override, and a prescaler that stretches each
// sequence step to DIV clock cycles. Simultaneous requests are resolved by a
// fixed priority. Every output is registered.
//
// Parameters
//   LAMPS        lamps per side (>=1); bit 0 is the innermost lamp
//   DIV          clock cycles per sequence step (>=1)
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   left         left-turn request (level)
//   right        right-turn request (level)
//   hazard       hazard request (level)
//   brake        brake pedal (level)
//   left_lamps   left lamp states, 1 = lit
//   right_lamps  right lamp states, 1 = lit
//   mode         current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD

module thunderbird_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic [1:0]       mode
);

  // The step counter must reach LAMPS. The prescaler keeps at least one bit
  // so the design still elaborates when DIV=1.
  localparam int SW = $clog2(LAMPS + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  mode_t            mode_q;
  mode_t            mode_d;
  mode_t            req_mode;
  logic [SW-1:0]    step_q;
  logic [SW-1:0]    step_d;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic [LAMPS-1:0] left_d;
  logic [LAMPS-1:0] right_d;
  logic [LAMPS-1:0] therm;
  logic             tick;

  // Request priority: an explicit hazard request wins. Left and right
  // requested together also mean hazard. A single turn request comes next,
  // and IDLE applies when nothing is requested.
  always_comb begin
    req_mode = MODE_IDLE;
    if (hazard || (left && right)) begin
      req_mode = MODE_HAZARD;
    end else if (left) begin
      req_mode = MODE_LEFT;
    end else if (right) begin
      req_mode = MODE_RIGHT;
    end
  end

  // Next-state logic for mode, step and prescaler.
  // A change of requested mode always restarts the sequence from step 0, so
  // an interrupted pattern is abandoned and not finished. IDLE keeps the
  // counters parked at zero. In the other modes the prescaler divides the
  // clock, and each tick advances the step.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    pre_d  = pre_q;
    tick   = 1'b0;
    if (req_mode != mode_q) begin
      mode_d = req_mode;
      step_d = '0;
      pre_d  = '0;
    end else if (mode_q == MODE_IDLE) begin
      step_d = '0;
      pre_d  = '0;
    end else begin
      tick = (pre_q == PRE_LAST);
      if (tick) begin
        pre_d = '0;
        if (mode_q == MODE_HAZARD) begin
          step_d = (step_q == '0) ? SW'(1) : '0;
        end else begin
          step_d = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // The lamp values are built from the next-state step and mode, so the
  // registered outputs change on the same edge as the state.
  // The active side shows a thermometer code: lamp i is lit when i < step.
  always_comb begin
    therm = '0;
    for (int i = 0; i < LAMPS; i++) begin
      therm[i] = (step_d > SW'(i));
    end
  end

  // Side selection. Any side that is not sequencing follows the brake
  // pedal. Hazard ignores the brake and flashes both sides together.
  always_comb begin
    left_d  = '0;
    right_d = '0;
    unique case (mode_d)
      MODE_IDLE: begin
        left_d  = {LAMPS{brake}};
        right_d = {LAMPS{brake}};
      end
      MODE_LEFT: begin
        left_d  = therm;
        right_d = {LAMPS{brake}};
      end
      MODE_RIGHT: begin
        left_d  = {LAMPS{brake}};
        right_d = therm;
      end
      MODE_HAZARD: begin
        left_d  = {LAMPS{step_d != '0}};
        right_d = {LAMPS{step_d != '0}};
      end
      default: begin
        left_d  = '0;
        right_d = '0;
      end
    endcase
  end

  // State and output registers. Reset clears them immediately, without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_IDLE;
      step_q      <= '0;
      pre_q       <= '0;
      left_lamps  <= '0;
      right_lamps <= '0;
    end else begin
      mode_q      <= mode_d;
      step_q      <= step_d;
      pre_q       <= pre_d;
      left_lamps  <= left_d;
      right_lamps <= right_d;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_thunderbird_seq.sv
// tb_thunderbird_seq
// Self-checking bench for thunderbird_seq with LAMPS=3 and DIV=4. A reference
// model tracks the current mode and how many edges have passed since that
// mode was entered. From these it derives the step arithmetically and then
// computes the lamp patterns. Directed scenarios are followed by a randomized
// soak run.

module tb_thunderbird_seq;

  localparam int LAMPS = 3;
  localparam int DIV   = 4;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             left   = 1'b0;
  logic             right  = 1'b0;
  logic             hazard = 1'b0;
  logic             brake  = 1'b0;
  logic [LAMPS-1:0] left_lamps;
  logic [LAMPS-1:0] right_lamps;
  logic [1:0]       mode;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode (0..3) and edges elapsed since mode entry.
  int m_mode = 0;
  int m_age  = 0;

  thunderbird_seq #(.LAMPS(LAMPS), .DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left        (left),
    .right       (right),
    .hazard      (hazard),
    .brake       (brake),
    .left_lamps  (left_lamps),
    .right_lamps (right_lamps),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  // Mode requested by the switch inputs, following the priority order.
  function automatic int req_of(input logic h, input logic l, input logic r);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  // Expected lamps on one side, derived from the model's mode and its age.
  function automatic logic [LAMPS-1:0] model_lamps(input bit is_left);
    int step;
    int active;
    active = is_left ? 1 : 2;
    if (m_mode == 3) begin
      step = (m_age / DIV) % 2;
      return (step != 0) ? {LAMPS{1'b1}} : {LAMPS{1'b0}};
    end
    if (m_mode == active) begin
      step = (m_age / DIV) % (LAMPS + 1);
      return LAMPS'((1 << step) - 1);
    end
    return brake ? {LAMPS{1'b1}} : {LAMPS{1'b0}};
  endfunction

  // Wait for one rising edge, advance the model the same way, then move 1 time unit past the edge.
  task automatic clock_edge();
    int req;
    @(posedge clk);
    if (rst_n) begin
      req = req_of(hazard, left, right);
      if (req != m_mode) begin
        m_mode = req;
        m_age  = 0;
      end else if (m_mode != 0) begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic go_idle();
    left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    clock_edge();
    clock_edge();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; left = 1'b1; brake = 1'b1;
    m_mode = 0; m_age = 0;
    for (int c = 0; c < 5; c++) begin
      clock_edge();
      checks++;
      if (left_lamps !== 3'b000 || right_lamps !== 3'b000 || mode !== 2'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold got l=%b r=%b m=%0d want l=000 r=000 m=0",
                 left_lamps, right_lamps, mode);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clock_edge();
      checks++;
      if (left_lamps !== model_lamps(1) || right_lamps !== model_lamps(0) || mode !== 2'(m_mode)) begin
        errors++;
        $display("[TB] FAIL reset_release c=%0d got l=%b r=%b m=%0d want l=%b r=%b m=%0d",
                 c, left_lamps, right_lamps, mode, model_lamps(1), model_lamps(0), m_mode);
      end
    end
    #2;
    rst_n = 1'b0;
    m_mode = 0; m_age = 0;
    #1;
    checks++;
    if (left_lamps !== 3'b000 || right_lamps !== 3'b000 || mode !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_async got l=%b r=%b m=%0d want l=000 r=000 m=0",
               left_lamps, right_lamps, mode);
    end
    clock_edge();
    rst_n = 1'b1;
    go_idle();
  endtask

  task automatic test_left_sequence();
    logic [LAMPS-1:0] table_l [6];
    table_l = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    go_idle();
    left = 1'b1;
    for (int c = 0; c < 24; c++) begin
      clock_edge();
      checks++;
      if (left_lamps !== model_lamps(1) || right_lamps !== 3'b000 || mode !== 2'd1) begin
        errors++;
        $display("[TB] FAIL left_seq c=%0d got l=%b r=%b m=%0d want l=%b r=000 m=1",
                 c, left_lamps, right_lamps, mode, model_lamps(1));
      end
      if (c % 4 == 0) begin
        checks++;
        if (left_lamps !== table_l[c/4]) begin
          errors++;
          $display("[TB] FAIL left_table c=%0d got %b want %b", c, left_lamps, table_l[c/4]);
        end
      end
    end
  endtask

  task automatic test_right_brake();
    go_idle();
    right = 1'b1; brake = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 18) brake = 1'b0;
      clock_edge();
      checks++;
      if (right_lamps !== model_lamps(0) || mode !== 2'd2 ||
          left_lamps !== ((c < 18) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("[TB] FAIL right_brake c=%0d got l=%b r=%b m=%0d want l=%b r=%b m=2",
                 c, left_lamps, right_lamps, mode, (c < 18) ? 3'b111 : 3'b000, model_lamps(0));
      end
    end
  endtask

  task automatic test_hazard();
    logic [LAMPS-1:0] table_h [3];
    table_h = '{3'b000, 3'b111, 3'b000};
    go_idle();
    left = 1'b1; right = 1'b1;
    for (int c = 0; c < 16; c++) begin
      clock_edge();
      checks++;
      if (left_lamps !== model_lamps(1) || right_lamps !== model_lamps(0) || mode !== 2'd3) begin
        errors++;
        $display("[TB] FAIL hazard c=%0d got l=%b r=%b m=%0d want l=%b r=%b m=3",
                 c, left_lamps, right_lamps, mode, model_lamps(1), model_lamps(0));
      end
      if (c % 4 == 0 && c < 12) begin
        checks++;
        if (left_lamps !== table_h[c/4] || right_lamps !== table_h[c/4]) begin
          errors++;
          $display("[TB] FAIL hazard_table c=%0d got l=%b r=%b want %b",
                   c, left_lamps, right_lamps, table_h[c/4]);
        end
      end
      if (c == 6) brake = 1'b1;
    end
  endtask

  task automatic test_mid_switch();
    bit found;
    go_idle();
    left = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      clock_edge();
      if (left_lamps === 3'b011) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL mid_switch_wait got l=%b want 011 within 20 edges", left_lamps);
    end
    left = 1'b0; right = 1'b1;
    clock_edge();
    checks++;
    if (mode !== 2'd2 || left_lamps !== 3'b000 || right_lamps !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_switch_entry got l=%b r=%b m=%0d want l=000 r=000 m=2",
               left_lamps, right_lamps, mode);
    end
    for (int k = 1; k <= 4; k++) begin
      clock_edge();
      checks++;
      if (right_lamps !== ((k < 4) ? 3'b000 : 3'b001) || right_lamps !== model_lamps(0)) begin
        errors++;
        $display("[TB] FAIL mid_switch_step k=%0d got r=%b want %b",
                 k, right_lamps, (k < 4) ? 3'b000 : 3'b001);
      end
    end
  endtask

  task automatic test_idle_brake();
    go_idle();
    brake = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) brake = 1'b0;
      clock_edge();
      checks++;
      if (left_lamps !== ((c < 3) ? 3'b111 : 3'b000) ||
          right_lamps !== ((c < 3) ? 3'b111 : 3'b000) || mode !== 2'd0) begin
        errors++;
        $display("[TB] FAIL idle_brake c=%0d got l=%b r=%b m=%0d want both %b m=0",
                 c, left_lamps, right_lamps, mode, (c < 3) ? 3'b111 : 3'b000);
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(7) == 0) left   = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) right  = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) hazard = 1'($urandom_range(1));
      if ($urandom_range(5) == 0) brake  = 1'($urandom_range(1));
      clock_edge();
      checks++;
      if (left_lamps !== model_lamps(1) || right_lamps !== model_lamps(0) || mode !== 2'(m_mode)) begin
        errors++;
        $display("[TB] FAIL random c=%0d got l=%b r=%b m=%0d want l=%b r=%b m=%0d",
                 c, left_lamps, right_lamps, mode, model_lamps(1), model_lamps(0), m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_sequence();
    test_right_brake();
    test_hazard();
    test_mid_switch();
    test_idle_brake();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
